zorro2_autoconfig: RTL and testbench
====================================

# zorro2_autoconfig

Parametrised Zorro II AutoConfig controller for the A500 expansion CPLD, presenting up to NUM_BOARDS logical boards (e.g. Fast RAM, IDE) one after another in the $E80000 config space. It serves inverted nibble reads on D15..D12, latches each board's assigned 8-bit base address from host writes, supports shut-up, and drives per-board address-select lines plus the /CFGOUT chain output. It replaces the fixed single-board, fixed-address RAM autoconfig logic.

## Interface
- NUM_BOARDS, 2, number of logical boards, 1..4; board 0 is configured first.
- BOARD_TYPE, {8'hC1,8'hE6}, er_Type per board, packed [8*i+7:8*i]; bits 7..6 = 11; bit 3 (chain) is ignored and generated internally; bits 2..0 = size code.
- BOARD_PRODUCT, {8'h12,8'h11}, er_Product per board.
- BOARD_FLAGS, {8'h00,8'hC0}, er_Flags per board.
- BOARD_MANUF, {16'h1111,16'h1111}, manufacturer ID per board, packed 16 bits per board.
- BOARD_SERIAL, 0, serial number per board, packed 32 bits per board.
- cpu_clk  in  1  CPU clock (7.09 MHz).
- cpu_nreset  in  1  Reset; **reset cpu_nreset, asynchronous, active-low; clock cpu_clk.**
- cpu_addr  in  23  CPU address A23..A1.
- cpu_nas, cpu_nuds, cpu_nlds  in  1 each  68000 strobes.
- cpu_rnw  in  1  Read/write, high = read.
- cpu_d_in  in  4  D15..D12 from the bus.
- cpu_d_out  out  4  D15..D12 to the bus.
- cpu_d_oe  out  1  Enables cpu_d_out onto the bus.
- cpu_ncfgin  in  1  Chain input; low = this card may configure.
- cpu_ncfgout  out  1  Chain output; low once all boards are configured or shut up.
- board_sel  out  NUM_BOARDS  Per-board address hit, combinational.
- board_base  out  8*NUM_BOARDS  Latched A23..A16 base per board.

## Operation
- Per-board state: UNCFG, CONFIGURED, SHUTUP.
- Active board: the lowest-index board in UNCFG. There is none when all boards are done.
- Config hit: cpu_addr[23:16] == 8'hE8, cpu_ncfgin == 0, and an active board exists.
- Read ROM, indexed by cpu_addr[6:1]:
  - $00/$02: type high/low nibble, not inverted. The chain bit is set for every board except the last.
  - $04/$06: product.
  - $08/$0A: flags.
  - $10..$16: manufacturer.
  - $18..$26: serial.
  - All of the above except $00/$02 are returned inverted.
  - $40/$42: 0, not inverted.
  - Any other offset: 4'hF.
- cpu_d_oe = read_cycle & config hit. cpu_d_out is valid whenever cpu_d_oe is high.
- Writes to the active board:
  - $4A: base[3:0] <= cpu_d_in.
  - $48: base[7:4] <= cpu_d_in, and the board goes UNCFG -> CONFIGURED.
- board_sel[i] = CONFIGURED & ((cpu_addr[23:16] ^ base) & mask(size)) == 0.
  - mask for size codes: 001 (64K) = 8'hFF; 010 = FE; 011 = FC; 100 = F8; 101 = F0; 110 (2M) = E0; 111 (4M) = C0; 000 (8M) = 80.
- SHUTUP boards never assert board_sel.
- cpu_ncfgout = 0 when no board is in UNCFG.

## Timing
- Cycle start is the first cpu_clk rising edge with cpu_nas = 0 whose 1-cycle-delayed sample of cpu_nas was 1.
- read_cycle / write_cycle are set at cycle start from cpu_rnw, and cleared asynchronously by cpu_nas = 1.
- Write commit: the first cpu_clk rising edge inside write_cycle with cpu_nuds = 0. A done flag gives exactly one commit per cycle.
- State advance is visible on the next read; board_sel updates the clock after the $48 commit.
- A write with cpu_nuds held high for the whole cycle is ignored.
- Reset values: all boards UNCFG; board_base = 0; cpu_d_oe = 0; cpu_d_out = 4'hF; board_sel = 0; cpu_ncfgout = 1.
- Reset asserted mid-cycle aborts the cycle and returns to the reset values immediately.

## Configuration
- AUTOCONFIG_SHUTUP_EN defined: a write to $4C/$4E moves the active board UNCFG -> SHUTUP and leaves its base unchanged.
- AUTOCONFIG_SHUTUP_EN undefined: $4C/$4E writes are ignored.

## Structure
- zorro2_autoconfig_pkg holds:
  - the board state enum;
  - register offset constants ($00, $48, $4A, $4C, $40);
  - function size_mask(size[2:0]) -> 8-bit mask.
- Sub-module zorro2_autoconfig_rom, one instance per board: combinational nibble lookup from cpu_addr[6:1] plus that board's parameters and chain bit.
- The top level muxes the active board's nibble.

## Test plan
- After reset, read $E80000/$E80002 -> 4'hE/4'hE (board 0, chain set); read $E80004 -> 4'hE; read $E80040 -> 4'h0; cpu_ncfgout = 1.
- Write $4A nibble 4'h0, then $48 nibble 4'h2 -> board_base[7:0] = 8'h20. An access to $3FFFFE gives board_sel[0] = 1; an access to $400000 gives board_sel[0] = 0.
- After board 0 is configured, read $E80000/$E80002 -> 4'hC/4'h1 (board 1, 64K, chain clear). Write $48 = 4'hE, $4A first = 4'h9 -> base 8'hE9, cpu_ncfgout = 0, and later config reads give cpu_d_oe = 0.
- With AUTOCONFIG_SHUTUP_EN, write $4C to board 0 -> board 0 in SHUTUP, board_sel[0] never asserts, board 1 becomes active. Without the macro, the same write has no effect.
- Hold cpu_ncfgin = 1 and read $E80000 -> cpu_d_oe = 0; a write to $48 changes no state.
- Assert cpu_nreset while board 0 is CONFIGURED and a read cycle is active -> cpu_d_oe = 0 and board_sel = 0 immediately, and board 0 is back in UNCFG.

Source files
------------

// File: rtl/zorro2_autoconfig_pkg.sv
// Shared types, register offsets and size decoding for the Zorro II AutoConfig controller.
package zorro2_autoconfig_pkg;

  typedef enum logic [1:0] {
    ST_UNCFG      = 2'd0,
    ST_CONFIGURED = 2'd1,
    ST_SHUTUP     = 2'd2
  } board_state_e;

  // Byte offsets within the $E80000 config window
  localparam logic [6:0] OFS_TYPE    = 7'h00;
  localparam logic [6:0] OFS_BASE_HI = 7'h48;
  localparam logic [6:0] OFS_BASE_LO = 7'h4A;
  localparam logic [6:0] OFS_SHUTUP  = 7'h4C;
  localparam logic [6:0] OFS_ZERO    = 7'h40;

  // Which of A23..A16 take part in the base compare for a given er_Type size code
  function automatic logic [7:0] size_mask(input logic [2:0] size);
    case (size)
      3'b001:  return 8'hFF;
      3'b010:  return 8'hFE;
      3'b011:  return 8'hFC;
      3'b100:  return 8'hF8;
      3'b101:  return 8'hF0;
      3'b110:  return 8'hE0;
      3'b111:  return 8'hC0;
      default: return 8'h80;
    endcase
  endfunction

endpackage

// File: rtl/zorro2_autoconfig_rom.sv
// Per-board AutoConfig nibble ROM; returns the D15..D12 value for one config-space offset.
module zorro2_autoconfig_rom
  import zorro2_autoconfig_pkg::*;
#(
  parameter logic [7:0]  ER_TYPE    = 8'hC1,
  parameter logic [7:0]  ER_PRODUCT = 8'h00,
  parameter logic [7:0]  ER_FLAGS   = 8'h00,
  parameter logic [15:0] ER_MANUF   = 16'h0000,
  parameter logic [31:0] ER_SERIAL  = 32'h0,
  parameter logic        CHAIN      = 1'b0
) (
  input  logic [5:0] idx_i,
  output logic [3:0] nib_o
);

  localparam logic [7:0] TYPE_EFF = {ER_TYPE[7:4], CHAIN, ER_TYPE[2:0]};

  logic [6:0] ofs;
  assign ofs = {idx_i, 1'b0};

  // Only the type byte and the $40 pair are presented true; everything else is inverted
  always_comb begin
    nib_o = 4'hF;
    case (ofs)
      OFS_TYPE:       nib_o = TYPE_EFF[7:4];
      OFS_TYPE + 7'h2: nib_o = TYPE_EFF[3:0];
      7'h04:          nib_o = ~ER_PRODUCT[7:4];
      7'h06:          nib_o = ~ER_PRODUCT[3:0];
      7'h08:          nib_o = ~ER_FLAGS[7:4];
      7'h0A:          nib_o = ~ER_FLAGS[3:0];
      7'h10:          nib_o = ~ER_MANUF[15:12];
      7'h12:          nib_o = ~ER_MANUF[11:8];
      7'h14:          nib_o = ~ER_MANUF[7:4];
      7'h16:          nib_o = ~ER_MANUF[3:0];
      7'h18:          nib_o = ~ER_SERIAL[31:28];
      7'h1A:          nib_o = ~ER_SERIAL[27:24];
      7'h1C:          nib_o = ~ER_SERIAL[23:20];
      7'h1E:          nib_o = ~ER_SERIAL[19:16];
      7'h20:          nib_o = ~ER_SERIAL[15:12];
      7'h22:          nib_o = ~ER_SERIAL[11:8];
      7'h24:          nib_o = ~ER_SERIAL[7:4];
      7'h26:          nib_o = ~ER_SERIAL[3:0];
      OFS_ZERO:       nib_o = 4'h0;
      OFS_ZERO + 7'h2: nib_o = 4'h0;
      default:        nib_o = 4'hF;
    endcase
  end

endmodule

// File: rtl/zorro2_autoconfig.sv
// Zorro II AutoConfig controller presenting NUM_BOARDS logical boards in sequence.
// Optional: define AUTOCONFIG_SHUTUP_EN to honour $4C/$4E shut-up writes.
module zorro2_autoconfig
  import zorro2_autoconfig_pkg::*;
#(
  parameter int                        NUM_BOARDS    = 2,
  parameter logic [8*NUM_BOARDS-1:0]   BOARD_TYPE    = {8'hC1, 8'hE6},
  parameter logic [8*NUM_BOARDS-1:0]   BOARD_PRODUCT = {8'h12, 8'h11},
  parameter logic [8*NUM_BOARDS-1:0]   BOARD_FLAGS   = {8'h00, 8'hC0},
  parameter logic [16*NUM_BOARDS-1:0]  BOARD_MANUF   = {16'h1111, 16'h1111},
  parameter logic [32*NUM_BOARDS-1:0]  BOARD_SERIAL  = '0
) (
  input  logic                      cpu_clk,
  input  logic                      cpu_nreset,
  input  logic [23:1]               cpu_addr,
  input  logic                      cpu_nas,
  input  logic                      cpu_nuds,
  input  logic                      cpu_nlds,
  input  logic                      cpu_rnw,
  input  logic [3:0]                cpu_d_in,
  output logic [3:0]                cpu_d_out,
  output logic                      cpu_d_oe,
  input  logic                      cpu_ncfgin,
  output logic                      cpu_ncfgout,
  output logic [NUM_BOARDS-1:0]     board_sel,
  output logic [8*NUM_BOARDS-1:0]   board_base
);

  board_state_e                 st_q [NUM_BOARDS];
  board_state_e                 st_d [NUM_BOARDS];
  logic [NUM_BOARDS-1:0][7:0]   base_q, base_d;
  logic [NUM_BOARDS-1:0][3:0]   nib;
  logic [NUM_BOARDS-1:0]        act_oh;
  logic                         found;
  logic                         nas_q, read_q, write_q, done_q;
  logic                         cyc_start, read_cycle, write_cycle, commit, cfg_hit;
  logic [3:0]                   rd_nib;
  logic [6:0]                   ofs;
  logic                         unused_bits;

  assign unused_bits = ^{cpu_nlds, cpu_addr[15:7]};
  assign ofs         = {cpu_addr[6:1], 1'b0};

  // Bus cycle tracking; AS high drops the cycle flags without waiting for a clock
  assign cyc_start   = ~cpu_nas & nas_q;
  assign read_cycle  = read_q  & ~cpu_nas;
  assign write_cycle = write_q & ~cpu_nas;
  assign commit      = write_cycle & ~cpu_nuds & ~done_q;

  always_ff @(posedge cpu_clk or negedge cpu_nreset) begin
    if (!cpu_nreset) begin
      nas_q   <= 1'b1;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      nas_q <= cpu_nas;
      if (cpu_nas) begin
        read_q  <= 1'b0;
        write_q <= 1'b0;
        done_q  <= 1'b0;
      end else if (cyc_start) begin
        read_q  <= cpu_rnw;
        write_q <= ~cpu_rnw;
        done_q  <= 1'b0;
      end else if (commit) begin
        done_q  <= 1'b1;
      end
    end
  end

  // Active board: lowest index still unconfigured
  always_comb begin
    found  = 1'b0;
    act_oh = '0;
    for (int i = 0; i < NUM_BOARDS; i++) begin
      act_oh[i] = (st_q[i] == ST_UNCFG) & ~found;
      found     = found | (st_q[i] == ST_UNCFG);
    end
  end

  assign cfg_hit     = (cpu_addr[23:16] == 8'hE8) & ~cpu_ncfgin & found;
  assign cpu_ncfgout = found;

  always_comb begin
    st_d   = st_q;
    base_d = base_q;
    for (int i = 0; i < NUM_BOARDS; i++) begin
      if (commit && cfg_hit && act_oh[i]) begin
        if (ofs == OFS_BASE_LO) begin
          base_d[i][3:0] = cpu_d_in;
        end else if (ofs == OFS_BASE_HI) begin
          base_d[i][7:4] = cpu_d_in;
          st_d[i]        = ST_CONFIGURED;
        end
`ifdef AUTOCONFIG_SHUTUP_EN
        else if ({ofs[6:2], 2'b00} == OFS_SHUTUP) begin
          st_d[i] = ST_SHUTUP;
        end
`endif
      end
    end
  end

  always_ff @(posedge cpu_clk or negedge cpu_nreset) begin
    if (!cpu_nreset) begin
      for (int i = 0; i < NUM_BOARDS; i++) st_q[i] <= ST_UNCFG;
      base_q <= '0;
    end else begin
      for (int i = 0; i < NUM_BOARDS; i++) st_q[i] <= st_d[i];
      base_q <= base_d;
    end
  end

  for (genvar i = 0; i < NUM_BOARDS; i++) begin : g_board
    zorro2_autoconfig_rom #(
      .ER_TYPE    (BOARD_TYPE[8*i +: 8]),
      .ER_PRODUCT (BOARD_PRODUCT[8*i +: 8]),
      .ER_FLAGS   (BOARD_FLAGS[8*i +: 8]),
      .ER_MANUF   (BOARD_MANUF[16*i +: 16]),
      .ER_SERIAL  (BOARD_SERIAL[32*i +: 32]),
      .CHAIN      (i != NUM_BOARDS - 1)
    ) u_rom (
      .idx_i (cpu_addr[6:1]),
      .nib_o (nib[i])
    );

    assign board_sel[i] = (st_q[i] == ST_CONFIGURED) &&
                          (((cpu_addr[23:16] ^ base_q[i]) & size_mask(BOARD_TYPE[8*i +: 3])) == 8'h00);
  end

  always_comb begin
    rd_nib = '0;
    for (int i = 0; i < NUM_BOARDS; i++)
      if (act_oh[i]) rd_nib = rd_nib | nib[i];
  end

  assign cpu_d_oe   = read_cycle & cfg_hit;
  assign cpu_d_out  = cpu_d_oe ? rd_nib : 4'hF;
  assign board_base = base_q;

endmodule

// File: tb/tb_zorro2_autoconfig.sv
// Randomized self-checking bench for zorro2_autoconfig against a behavioural board model.
module tb_zorro2_autoconfig;

  localparam int          NB     = 2;
  localparam logic [15:0] TYPES  = {8'hC1, 8'hE6};
  localparam logic [15:0] PRODS  = {8'h12, 8'h11};
  localparam logic [15:0] BFLAGS = {8'h00, 8'hC0};
  localparam logic [31:0] MANUF  = {16'h1111, 16'h1111};
  localparam logic [63:0] SERIAL = '0;

  logic           cpu_clk = 1'b0;
  logic           cpu_nreset = 1'b0;
  logic [23:1]    cpu_addr = '0;
  logic           cpu_nas = 1'b1, cpu_nuds = 1'b1, cpu_nlds = 1'b1, cpu_rnw = 1'b1;
  logic [3:0]     cpu_d_in = '0;
  logic [3:0]     cpu_d_out;
  logic           cpu_d_oe;
  logic           cpu_ncfgin = 1'b0;
  logic           cpu_ncfgout;
  logic [NB-1:0]  board_sel;
  logic [8*NB-1:0] board_base;

  int n_chk = 0;
  int n_fail = 0;

  // model: 0 = unconfigured, 1 = configured, 2 = shut up
  int         m_state [NB];
  logic [7:0] m_base  [NB];

  zorro2_autoconfig dut (
    .cpu_clk(cpu_clk), .cpu_nreset(cpu_nreset), .cpu_addr(cpu_addr),
    .cpu_nas(cpu_nas), .cpu_nuds(cpu_nuds), .cpu_nlds(cpu_nlds), .cpu_rnw(cpu_rnw),
    .cpu_d_in(cpu_d_in), .cpu_d_out(cpu_d_out), .cpu_d_oe(cpu_d_oe),
    .cpu_ncfgin(cpu_ncfgin), .cpu_ncfgout(cpu_ncfgout),
    .board_sel(board_sel), .board_base(board_base)
  );

  always #5 cpu_clk = ~cpu_clk;

  initial begin
    #900000;
    $display("FAIL watchdog expired: time %0t limit 900000", $time);
    $fatal(1, "watchdog");
  end

  function automatic void m_reset();
    for (int i = 0; i < NB; i++) begin m_state[i] = 0; m_base[i] = 8'h00; end
  endfunction

  function automatic int m_active();
    for (int i = 0; i < NB; i++) if (m_state[i] == 0) return i;
    return -1;
  endfunction

  function automatic logic [3:0] m_rom(input int b, input logic [6:0] ofs);
    logic [7:0] ty;
    logic [3:0] img [20];
    logic [3:0] r;
    int n;
    ty = TYPES[8*b +: 8];
    ty[3] = (b != NB - 1);
    img[0] = ty[7:4];                 img[1] = ty[3:0];
    img[2] = PRODS[8*b+4 +: 4];       img[3] = PRODS[8*b +: 4];
    img[4] = BFLAGS[8*b+4 +: 4];      img[5] = BFLAGS[8*b +: 4];
    img[6] = 4'hF;                    img[7] = 4'hF;
    for (int k = 0; k < 4; k++) img[8+k]  = MANUF[16*b + 12 - 4*k +: 4];
    for (int k = 0; k < 8; k++) img[12+k] = SERIAL[32*b + 28 - 4*k +: 4];
    n = int'(ofs) / 2;
    if (n < 20) begin
      r = img[n];
      if (n >= 2 && n != 6 && n != 7) r = ~r;
    end else if (n == 32 || n == 33) r = 4'h0;
    else r = 4'hF;
    return r;
  endfunction

  function automatic void m_read(input logic [23:0] a, input logic ncfg,
                                 output logic oe, output logic [3:0] d);
    oe = (a[23:16] == 8'hE8) && !ncfg && (m_active() >= 0);
    d  = oe ? m_rom(m_active(), {a[6:1], 1'b0}) : 4'hF;
  endfunction

  function automatic void m_write(input logic [23:0] a, input logic [3:0] nib,
                                  input logic uds_on, input logic ncfg);
    int b;
    logic [6:0] ofs;
    b = m_active();
    ofs = {a[6:1], 1'b0};
    if (a[23:16] != 8'hE8 || ncfg || !uds_on || b < 0) return;
    if (ofs == 7'h4A) m_base[b][3:0] = nib;
    else if (ofs == 7'h48) begin m_base[b][7:4] = nib; m_state[b] = 1; end
`ifdef AUTOCONFIG_SHUTUP_EN
    else if (ofs == 7'h4C || ofs == 7'h4E) m_state[b] = 2;
`endif
  endfunction

  // Board decodes a power-of-two block of 64K units aligned to its size
  function automatic logic [NB-1:0] m_sel(input logic [7:0] a8);
    logic [NB-1:0] v;
    int code, lg;
    for (int i = 0; i < NB; i++) begin
      code = int'(TYPES[8*i +: 3]);
      lg   = (code == 0) ? 7 : code - 1;
      v[i] = (m_state[i] == 1) && ((a8 >> lg) == (m_base[i] >> lg));
    end
    return v;
  endfunction

  function automatic logic [8*NB-1:0] m_bases();
    logic [8*NB-1:0] v;
    for (int i = 0; i < NB; i++) v[8*i +: 8] = m_base[i];
    return v;
  endfunction

  task automatic do_reset();
    @(negedge cpu_clk);
    cpu_nreset = 1'b0; cpu_nas = 1'b1; cpu_nuds = 1'b1; cpu_nlds = 1'b1; cpu_rnw = 1'b1;
    cpu_ncfgin = 1'b0;
    repeat (2) @(negedge cpu_clk);
    cpu_nreset = 1'b1;
    m_reset();
  endtask

  task automatic bus_read(input logic [23:0] a, output logic [3:0] d, output logic oe);
    @(negedge cpu_clk);
    cpu_addr = a[23:1]; cpu_rnw = 1'b1; cpu_nas = 1'b0; cpu_nuds = 1'b0; cpu_nlds = 1'b0;
    @(posedge cpu_clk); @(posedge cpu_clk); @(negedge cpu_clk);
    d = cpu_d_out; oe = cpu_d_oe;
    cpu_nas = 1'b1; cpu_nuds = 1'b1; cpu_nlds = 1'b1;
  endtask

  task automatic bus_write(input logic [23:0] a, input logic [3:0] nib, input logic uds_on);
    @(negedge cpu_clk);
    cpu_addr = a[23:1]; cpu_rnw = 1'b0; cpu_d_in = nib;
    cpu_nas = 1'b0; cpu_nuds = ~uds_on; cpu_nlds = 1'b0;
    repeat (3) @(posedge cpu_clk);
    @(negedge cpu_clk);
    cpu_nas = 1'b1; cpu_nuds = 1'b1; cpu_nlds = 1'b1; cpu_rnw = 1'b1;
    m_write(a, nib, uds_on, cpu_ncfgin);
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge cpu_clk);
    n_chk++; if (cpu_d_oe !== 1'b0) begin n_fail++; $display("FAIL reset_oe got %b exp 0", cpu_d_oe); end
    n_chk++; if (cpu_d_out !== 4'hF) begin n_fail++; $display("FAIL reset_dout got %h exp F", cpu_d_out); end
    n_chk++; if (board_sel !== '0) begin n_fail++; $display("FAIL reset_sel got %b exp 0", board_sel); end
    n_chk++; if (cpu_ncfgout !== 1'b1) begin n_fail++; $display("FAIL reset_ncfgout got %b exp 1", cpu_ncfgout); end
    n_chk++; if (board_base !== '0) begin n_fail++; $display("FAIL reset_base got %h exp 0", board_base); end
  endtask

  task automatic test_rom_reads();
    logic [3:0] d, ed;
    logic oe, eoe;
    logic [23:0] a;
    logic [23:0] fixed [4] = '{24'hE80000, 24'hE80002, 24'hE80004, 24'hE80040};
    logic [3:0]  fexp  [4] = '{4'hE, 4'hE, 4'hE, 4'h0};
    for (int i = 0; i < 4; i++) begin
      bus_read(fixed[i], d, oe);
      n_chk++; if (oe !== 1'b1 || d !== fexp[i]) begin
        n_fail++; $display("FAIL rom_fixed @%h got oe=%b d=%h exp oe=1 d=%h", fixed[i], oe, d, fexp[i]); end
    end
    for (int i = 0; i < 16; i++) begin
      a = {8'hE8, 16'($urandom)};
      a[0] = 1'b0;
      bus_read(a, d, oe);
      m_read(a, 1'b0, eoe, ed);
      n_chk++; if (oe !== eoe || d !== ed) begin
        n_fail++; $display("FAIL rom_rand @%h got oe=%b d=%h exp oe=%b d=%h", a, oe, d, eoe, ed); end
    end
    n_chk++; if (cpu_ncfgout !== 1'b1) begin n_fail++; $display("FAIL rom_ncfgout got %b exp 1", cpu_ncfgout); end
  endtask

  task automatic test_configure();
    logic [3:0] d;
    logic oe;
    bus_write(24'hE8004A, 4'h0, 1'b1);
    bus_write(24'hE80048, 4'h2, 1'b1);
    n_chk++; if (board_base[7:0] !== 8'h20) begin n_fail++; $display("FAIL cfg0_base got %h exp 20", board_base[7:0]); end
    @(negedge cpu_clk); cpu_addr = 23'h3FFFFE >> 1;
    #1 n_chk++; if (board_sel[0] !== 1'b1) begin n_fail++; $display("FAIL cfg0_sel_in got %b exp 1", board_sel[0]); end
    cpu_addr = 23'h200000;
    #1 n_chk++; if (board_sel[0] !== 1'b0) begin n_fail++; $display("FAIL cfg0_sel_out got %b exp 0", board_sel[0]); end
    bus_read(24'hE80000, d, oe);
    n_chk++; if (oe !== 1'b1 || d !== 4'hC) begin n_fail++; $display("FAIL cfg1_type_hi got oe=%b d=%h exp 1/C", oe, d); end
    bus_read(24'hE80002, d, oe);
    n_chk++; if (oe !== 1'b1 || d !== 4'h1) begin n_fail++; $display("FAIL cfg1_type_lo got oe=%b d=%h exp 1/1", oe, d); end
    bus_write(24'hE8004A, 4'h9, 1'b1);
    bus_write(24'hE80048, 4'hE, 1'b1);
    n_chk++; if (board_base !== 16'hE920) begin n_fail++; $display("FAIL cfg1_base got %h exp E920", board_base); end
    n_chk++; if (cpu_ncfgout !== 1'b0) begin n_fail++; $display("FAIL cfg1_ncfgout got %b exp 0", cpu_ncfgout); end
    bus_read(24'hE80000, d, oe);
    n_chk++; if (oe !== 1'b0 || d !== 4'hF) begin n_fail++; $display("FAIL cfg_done_read got oe=%b d=%h exp 0/F", oe, d); end
    @(negedge cpu_clk); cpu_addr = 23'h000000 | (24'hE9ABCD >> 1);
    #1 n_chk++; if (board_sel !== 2'b10) begin n_fail++; $display("FAIL cfg1_sel got %b exp 10", board_sel); end
  endtask

  task automatic test_ncfgin_and_nuds();
    logic [3:0] d;
    logic oe;
    do_reset();
    cpu_ncfgin = 1'b1;
    bus_read(24'hE80000, d, oe);
    n_chk++; if (oe !== 1'b0) begin n_fail++; $display("FAIL ncfgin_read got oe=%b exp 0", oe); end
    bus_write(24'hE80048, 4'h5, 1'b1);
    n_chk++; if (board_base !== '0 || cpu_ncfgout !== 1'b1) begin
      n_fail++; $display("FAIL ncfgin_write got base=%h ncfgout=%b exp 0/1", board_base, cpu_ncfgout); end
    cpu_ncfgin = 1'b0;
    bus_write(24'hE80048, 4'h5, 1'b0);
    n_chk++; if (board_base !== '0) begin n_fail++; $display("FAIL nuds_high_base got %h exp 0", board_base); end
    bus_read(24'hE80000, d, oe);
    n_chk++; if (oe !== 1'b1 || d !== 4'hE) begin n_fail++; $display("FAIL nuds_high_active got oe=%b d=%h exp 1/E", oe, d); end
  endtask

  task automatic test_shutup();
    logic [3:0] d, exp_hi;
    logic oe;
    logic [NB-1:0] es;
    do_reset();
    bus_write(24'hE8004C, 4'h0, 1'b1);
`ifdef AUTOCONFIG_SHUTUP_EN
    exp_hi = 4'hC;
`else
    exp_hi = 4'hE;
`endif
    bus_read(24'hE80000, d, oe);
    n_chk++; if (oe !== 1'b1 || d !== exp_hi) begin n_fail++; $display("FAIL shutup_next got oe=%b d=%h exp 1/%h", oe, d, exp_hi); end
    bus_write(24'hE80048, 4'h0, 1'b1);
    @(negedge cpu_clk); cpu_addr = '0;
    es = m_sel(8'h00);
    #1 n_chk++; if (board_sel !== es) begin n_fail++; $display("FAIL shutup_sel got %b exp %b", board_sel, es); end
  endtask

  task automatic test_reset_midcycle();
    do_reset();
    bus_write(24'hE8004A, 4'h0, 1'b1);
    bus_write(24'hE80048, 4'h2, 1'b1);
    @(negedge cpu_clk);
    cpu_addr = 24'hE80000 >> 1; cpu_rnw = 1'b1; cpu_nas = 1'b0; cpu_nuds = 1'b0; cpu_nlds = 1'b0;
    @(posedge cpu_clk); @(posedge cpu_clk); @(negedge cpu_clk);
    n_chk++; if (cpu_d_oe !== 1'b1 || cpu_d_out !== 4'hC) begin
      n_fail++; $display("FAIL midrst_pre got oe=%b d=%h exp 1/C", cpu_d_oe, cpu_d_out); end
    cpu_addr = 24'h200000 >> 1;
    #1 n_chk++; if (board_sel !== 2'b01) begin n_fail++; $display("FAIL midrst_sel_pre got %b exp 01", board_sel); end
    #1 cpu_nreset = 1'b0;
    #1 n_chk++; if (board_sel !== '0 || cpu_ncfgout !== 1'b1 || board_base !== '0) begin
      n_fail++; $display("FAIL midrst_state got sel=%b ncfgout=%b base=%h exp 0/1/0", board_sel, cpu_ncfgout, board_base); end
    cpu_addr = 24'hE80000 >> 1;
    #1 n_chk++; if (cpu_d_oe !== 1'b0) begin n_fail++; $display("FAIL midrst_oe got %b exp 0", cpu_d_oe); end
    @(negedge cpu_clk);
    cpu_nas = 1'b1; cpu_nuds = 1'b1; cpu_nlds = 1'b1;
    @(negedge cpu_clk);
    cpu_nreset = 1'b1;
    m_reset();
  endtask

  task automatic test_random();
    logic [3:0] d, ed, nib;
    logic oe, eoe, uds;
    logic [23:0] a;
    logic [7:0] ofs_tab [5] = '{8'h48, 8'h4A, 8'h4C, 8'h4E, 8'h00};
    logic [NB-1:0] es;
    int r;
    do_reset();
    for (int it = 0; it < 250; it++) begin
      r = $urandom_range(0, 19);
      cpu_ncfgin = ($urandom_range(0, 7) == 0);
      if (r < 8) begin
        a = 24'($urandom);
        if ($urandom_range(0, 3) != 0) a[23:16] = 8'hE8;
        a[0] = 1'b0;
        bus_read(a, d, oe);
        m_read(a, cpu_ncfgin, eoe, ed);
        n_chk++; if (oe !== eoe || d !== ed) begin
          n_fail++; $display("FAIL rand_read @%h got oe=%b d=%h exp oe=%b d=%h", a, oe, d, eoe, ed); end
      end else if (r < 17) begin
        a = {8'hE8, 16'($urandom)};
        if ($urandom_range(0, 4) != 4) a[7:0] = ofs_tab[$urandom_range(0, 3)];
        if ($urandom_range(0, 9) == 0) a[23:16] = 8'($urandom);
        a[0] = 1'b0;
        nib = 4'($urandom);
        uds = ($urandom_range(0, 5) != 0);
        bus_write(a, nib, uds);
      end else if (r == 17) begin
        do_reset();
      end
      cpu_ncfgin = 1'b0;
      @(negedge cpu_clk);
      a = 24'($urandom);
      cpu_addr = a[23:1];
      es = m_sel(a[23:16]);
      #1;
      n_chk++; if (board_sel !== es) begin n_fail++; $display("FAIL rand_sel @%h got %b exp %b", a, board_sel, es); end
      n_chk++; if (cpu_ncfgout !== (m_active() >= 0)) begin
        n_fail++; $display("FAIL rand_ncfgout got %b exp %b", cpu_ncfgout, m_active() >= 0); end
      n_chk++; if (board_base !== m_bases()) begin
        n_fail++; $display("FAIL rand_base got %h exp %h", board_base, m_bases()); end
    end
  endtask

  initial begin
    m_reset();
    test_reset();
    test_rom_reads();
    test_configure();
    test_ncfgin_and_nuds();
    test_shutup();
    test_reset_midcycle();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
